operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/calc_pkg.sv | 20 ++
 rtl/frame_timer.sv | 28 ++
 rtl/operand_loader.sv | 127 ++++++++++++
 tb/tb_operand_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the operand loader and its idle timer.
// No logic; opcode values, error codes, FSM state encoding and operand width.
// Backpressure: not applicable.
package calc_pkg;
   localparam int OPW = 8;

   localparam logic [OPW-1:0] OP_EQ_A = 8'h01;
   localparam logic [OPW-1:0] OP_EQ_B = 8'h00;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_OPCODE  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_WAIT
   } state_t;
endpackage

// File: rtl/frame_timer.sv
// Counts consecutive enabled cycles; expired flags the TIMEOUT-th one.
// Latency: expired is combinational on the cycle that reaches the limit.
// Backpressure: none; clear has priority over enable.
module frame_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= 8'd0;
      end else if (clear) begin
         cnt <= 8'd0;
      end else if (enable) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expired = enable && (cnt == LIMIT);
endmodule

// File: rtl/operand_loader.sv
// Parses opcode+operand frames and loads operand sets atomically for the controller.
// Latency: issue the cycle after the last operand, res_strobe one cycle later.
// Backpressure: in_ready drops for the ISSUE and WAIT cycles and during reset.
module operand_loader
   import calc_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [OPW-1:0]        in_data,
   output logic                  in_ready,
   output logic signed [OPW-1:0] x1,
   output logic signed [OPW-1:0] x2,
   output logic signed [OPW-1:0] v,
   output logic signed [OPW-1:0] t,
   output logic signed [OPW-1:0] c,
   output logic                  equationFlag,
   output logic                  issue,
   output logic                  res_strobe,
   output logic                  res_sel,
   output logic                  err,
   output logic [1:0]            err_code
);
   state_t         state;
   logic           pend_a;
   logic [1:0]     op_cnt;
   logic [OPW-1:0] stg0;
   logic [OPW-1:0] stg1;
   logic           xfer;
   logic           last_op;
   logic           expired;

   assign in_ready = rst_n && (state == ST_IDLE || state == ST_LOAD);
   assign xfer     = in_valid && in_ready;
   assign last_op  = pend_a ? (op_cnt == 2'd1) : (op_cnt == 2'd2);

   frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state != ST_LOAD || xfer),
      .enable  (state == ST_LOAD && !xfer),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pend_a       <= 1'b0;
         op_cnt       <= 2'd0;
         stg0         <= '0;
         stg1         <= '0;
         x1           <= '0;
         x2           <= '0;
         v            <= '0;
         t            <= '0;
         c            <= '0;
         equationFlag <= 1'b0;
         issue        <= 1'b0;
         res_strobe   <= 1'b0;
         res_sel      <= 1'b0;
         err          <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         issue      <= 1'b0;
         res_strobe <= 1'b0;
         res_sel    <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  if (in_data == OP_EQ_A || in_data == OP_EQ_B) begin
                     pend_a <= (in_data == OP_EQ_A);
                     op_cnt <= 2'd0;
                     state  <= ST_LOAD;
                  end else begin
                     err      <= 1'b1;
                     err_code <= ERR_OPCODE;
                  end
               end
            end
            ST_LOAD: begin
               if (xfer) begin
                  // Only the last operand touches the outputs, so the controller never sees a mixed set.
                  if (last_op) begin
                     if (pend_a) begin
                        x1 <= stg0;
                        x2 <= in_data;
                     end else begin
                        v <= stg0;
                        t <= stg1;
                        c <= in_data;
                     end
                     equationFlag <= pend_a;
                     issue        <= 1'b1;
                     state        <= ST_ISSUE;
                  end else begin
                     if (op_cnt == 2'd0) begin
                        stg0 <= in_data;
                     end else begin
                        stg1 <= in_data;
                     end
                     op_cnt <= op_cnt + 2'd1;
                  end
               end else if (expired) begin
                  err      <= 1'b1;
                  err_code <= ERR_TIMEOUT;
                  state    <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               res_strobe <= 1'b1;
               res_sel    <= equationFlag;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: vector table plus timeout, reset and streaming sequences.
module tb_operand_loader;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] x1, x2, v, t, c;
   logic       equationFlag, issue, res_strobe, res_sel, err;
   logic [1:0] err_code;

   int nvec = 0;
   int nbad = 0;

   operand_loader #(.TIMEOUT(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .x1           (x1),
      .x2           (x2),
      .v            (v),
      .t            (t),
      .c            (c),
      .equationFlag (equationFlag),
      .issue        (issue),
      .res_strobe   (res_strobe),
      .res_sel      (res_sel),
      .err          (err),
      .err_code     (err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [7:0] dat;
      logic       rdy;
      logic       iss;
      logic       stb;
      logic       sel;
      logic       er;
      logic [1:0] code;
      logic [40:0] ops;
   } vec_t;

   vec_t tbl[17];

   function automatic logic [40:0] pk(input logic [7:0] a, b, d, e, f, input logic q);
      return {a, b, d, e, f, q};
   endfunction

   function automatic vec_t mk(input logic vl, input logic [7:0] dt, input logic rd, is, sb, sl,
                               input logic ee, input logic [1:0] cd, input logic [40:0] op);
      vec_t r;
      r.vld = vl; r.dat = dt; r.rdy = rd; r.iss = is; r.stb = sb; r.sel = sl;
      r.er = ee; r.code = cd; r.ops = op;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [40:0] cur_ops();
      return {x1, x2, v, t, c, equationFlag};
   endfunction

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      chk("send_rdy", 64'(in_ready), 64'd1);
      step();
   endtask

   logic [7:0]  stream[10];
   logic [40:0] exp_iss[3];
   int idx, stalls, nissue, cyc;
   logic acc;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h01;
      #1;
      chk("rst_rdy", 64'(in_ready), 64'd0);
      step();
      step();
      chk("rst_ops", 64'(cur_ops()), 64'd0);
      chk("rst_flags", 64'({issue, res_strobe, res_sel, err, err_code}), 64'd0);
      chk("rst_rdy2", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();

      tbl[0]  = mk(1, 8'h01, 1, 0, 0, 0, 0, 2'b00, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
      tbl[1]  = mk(1, 8'h04, 1, 0, 0, 0, 0, 2'b00, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
      tbl[2]  = mk(1, 8'hFE, 1, 1, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h00, 8'h00, 8'h00, 1));
      tbl[3]  = mk(1, 8'h00, 0, 0, 1, 1, 0, 2'b00, pk(8'h04, 8'hFE, 8'h00, 8'h00, 8'h00, 1));
      tbl[4]  = mk(1, 8'h00, 0, 0, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h00, 8'h00, 8'h00, 1));
      tbl[5]  = mk(1, 8'h00, 1, 0, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h00, 8'h00, 8'h00, 1));
      tbl[6]  = mk(1, 8'h03, 1, 0, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h00, 8'h00, 8'h00, 1));
      tbl[7]  = mk(1, 8'hFB, 1, 0, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h00, 8'h00, 8'h00, 1));
      tbl[8]  = mk(1, 8'h07, 1, 1, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h03, 8'hFB, 8'h07, 0));
      tbl[9]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h03, 8'hFB, 8'h07, 0));
      tbl[10] = mk(0, 8'h00, 0, 0, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h03, 8'hFB, 8'h07, 0));
      tbl[11] = mk(1, 8'h82, 1, 0, 0, 0, 1, 2'b01, pk(8'h04, 8'hFE, 8'h03, 8'hFB, 8'h07, 0));
      tbl[12] = mk(1, 8'h01, 1, 0, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h03, 8'hFB, 8'h07, 0));
      tbl[13] = mk(1, 8'h01, 1, 0, 0, 0, 0, 2'b00, pk(8'h04, 8'hFE, 8'h03, 8'hFB, 8'h07, 0));
      tbl[14] = mk(1, 8'h01, 1, 1, 0, 0, 0, 2'b00, pk(8'h01, 8'h01, 8'h03, 8'hFB, 8'h07, 1));
      tbl[15] = mk(0, 8'h00, 0, 0, 1, 1, 0, 2'b00, pk(8'h01, 8'h01, 8'h03, 8'hFB, 8'h07, 1));
      tbl[16] = mk(0, 8'h00, 0, 0, 0, 0, 0, 2'b00, pk(8'h01, 8'h01, 8'h03, 8'hFB, 8'h07, 1));

      foreach (tbl[i]) begin
         in_valid = tbl[i].vld;
         in_data  = tbl[i].dat;
         #1;
         chk($sformatf("v%0d_rdy", i), 64'(in_ready), 64'(tbl[i].rdy));
         step();
         chk($sformatf("v%0d_issue", i), 64'(issue), 64'(tbl[i].iss));
         chk($sformatf("v%0d_strobe", i), 64'(res_strobe), 64'(tbl[i].stb));
         if (tbl[i].stb)
            chk($sformatf("v%0d_sel", i), 64'(res_sel), 64'(tbl[i].sel));
         chk($sformatf("v%0d_err", i), 64'({err, err_code}), 64'({tbl[i].er, tbl[i].code}));
         chk($sformatf("v%0d_ops", i), 64'(cur_ops()), 64'(tbl[i].ops));
      end

      // Timeout: 16 idle cycles after a partial frame
      send(8'h01);
      send(8'h05);
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         chk($sformatf("to_early%0d", i), 64'({err, err_code}), 64'd0);
      end
      step();
      chk("to_err", 64'({err, err_code}), 64'({1'b1, 2'b10}));
      chk("to_ops", 64'(cur_ops()), 64'(pk(8'h01, 8'h01, 8'h03, 8'hFB, 8'h07, 1)));
      chk("to_issue", 64'(issue), 64'd0);
      step();
      chk("to_err_clr", 64'({err, err_code}), 64'd0);

      // Reset mid-frame
      send(8'h00);
      send(8'h09);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h0A;
      #1;
      chk("mrst_rdy", 64'(in_ready), 64'd0);
      step();
      chk("mrst_ops", 64'(cur_ops()), 64'd0);
      chk("mrst_flags", 64'({issue, res_strobe, err, err_code}), 64'd0);
      step();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      step();
      chk("mrst_quiet", 64'({issue, res_strobe, err}), 64'd0);
      send(8'h01);
      send(8'h0A);
      send(8'h0B);
      chk("post_issue", 64'(issue), 64'd1);
      chk("post_ops", 64'(cur_ops()), 64'(pk(8'h0A, 8'h0B, 8'h00, 8'h00, 8'h00, 1)));
      in_valid = 1'b0;
      step();
      chk("post_strobe", 64'({res_strobe, res_sel}), 64'b11);
      step();

      // Back-to-back frames with in_valid held high
      stream = '{8'h01, 8'h11, 8'h22, 8'h00, 8'h33, 8'h44, 8'h55, 8'h01, 8'h66, 8'h77};
      exp_iss[0] = pk(8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 1);
      exp_iss[1] = pk(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 0);
      exp_iss[2] = pk(8'h66, 8'h77, 8'h33, 8'h44, 8'h55, 1);
      idx = 0; stalls = 0; nissue = 0; cyc = 0;
      in_valid = 1'b1;
      while (idx < 10 && cyc < 40) begin
         in_data = stream[idx];
         #1;
         acc = in_ready;
         if (!acc) stalls++;
         step();
         if (acc) idx++;
         if (issue) begin
            if (nissue < 3)
               chk($sformatf("b2b_ops%0d", nissue), 64'(cur_ops()), 64'(exp_iss[nissue]));
            nissue++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      chk("b2b_done", 64'(idx), 64'd10);
      chk("b2b_stalls", 64'(stalls), 64'd4);
      chk("b2b_issues", 64'(nissue), 64'd3);
      step();
      chk("b2b_strobe", 64'({res_strobe, res_sel}), 64'b11);
      step();
      #1;
      chk("b2b_idle_rdy", 64'(in_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
